// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
// Holds the FSM state encoding, the control-output bundle and its per-state decode.
package instr_loader_pkg;

  localparam int          LEN_W         = 16;
  localparam logic [31:0] BASE_ADDR_DEF = 32'hBFC00000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  typedef struct packed {
    logic byte_ready;
    logic mem_we;
    logic cpu_rst;
    logic done;
    logic err;
  } ctl_t;

  localparam ctl_t CTL_RST = '{byte_ready: 1'b0, mem_we: 1'b0, cpu_rst: 1'b1,
                               done: 1'b0, err: 1'b0};

  // Control outputs are a pure function of the state being entered.
  function automatic ctl_t ctl_of(state_t s);
    ctl_t c;
    c.byte_ready = (s == LEN_LO) || (s == LEN_HI) || (s == DATA);
    c.mem_we     = (s == WRITE);
    c.cpu_rst    = (s != DONE);
    c.done       = (s == DONE);
    c.err        = (s == ERR);
    return c;
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Collects four stream bytes into one little-endian word.
// word is the value the shift register takes if the current byte is shifted in.
module word_assembler
  import instr_loader_pkg::*;
#(
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               shift_en,
  input  logic [7:0]         byte_data,
  output logic [D_WIDTH-1:0] word,
  output logic               word_full
);

  logic [D_WIDTH-1:0] shreg;
  logic [1:0]         cnt;

  // New bytes enter at the top, so after four shifts the first byte sits in [7:0].
  assign word      = {byte_data, shreg[D_WIDTH-1:8]};
  assign word_full = shift_en && (cnt == 2'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg <= '0;
      cnt   <= 2'd0;
    end else if (clear) begin
      shreg <= '0;
      cnt   <= 2'd0;
    end else if (shift_en) begin
      shreg <= word;
      cnt   <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Loads a length-prefixed byte stream into instruction memory while holding the CPU in reset.
// Handshake: a byte moves on a rising edge where byte_valid and byte_ready are both 1.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int          A_WIDTH   = 8,
  parameter int          D_WIDTH   = 32,
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               byte_ready,
  output logic               mem_we,
  output logic [D_WIDTH-1:0] mem_addr,
  output logic [D_WIDTH-1:0] mem_wdata,
  output logic               cpu_rst,
  output logic               done,
  output logic               err,
  output logic [2:0]         dbg_state
);

  state_t             state, state_nxt;
  ctl_t               ctl;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   n_full;
  logic [A_WIDTH:0]   idx;
  logic               accept, start_ok, shift_en, too_long, last_word;
  logic [D_WIDTH-1:0] asm_word;
  logic               word_full;

  assign byte_ready = ctl.byte_ready;
  assign mem_we     = ctl.mem_we;
  assign cpu_rst    = ctl.cpu_rst;
  assign done       = ctl.done;
  assign err        = ctl.err;
  assign dbg_state  = state;

  assign accept    = byte_valid && ctl.byte_ready;
  assign start_ok  = start && ((state == IDLE) || (state == DONE) || (state == ERR));
  assign shift_en  = accept && (state == DATA);
  assign n_full    = {byte_data, len[7:0]};
  // Index is one bit wider than A_WIDTH so a full memory of words still terminates.
  assign too_long  = int'(n_full) > (1 << A_WIDTH);
  assign last_word = (int'(idx) + 1) == int'(len);

  word_assembler #(.D_WIDTH(D_WIDTH)) u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_ok),
    .shift_en  (shift_en),
    .byte_data (byte_data),
    .word      (asm_word),
    .word_full (word_full)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_nxt = LEN_LO;
      LEN_LO:          if (accept) state_nxt = LEN_HI;
      LEN_HI: begin
        if (accept) begin
          if (n_full == '0)  state_nxt = DONE;
          else if (too_long) state_nxt = ERR;
          else               state_nxt = DATA;
        end
      end
      DATA:    if (word_full) state_nxt = WRITE;
      WRITE:   state_nxt = last_word ? DONE : DATA;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ctl       <= CTL_RST;
      len       <= '0;
      idx       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_nxt;
      ctl   <= ctl_of(state_nxt);
      if (start_ok) begin
        len <= '0;
        idx <= '0;
      end
      if (accept && (state == LEN_LO)) len[7:0]  <= byte_data;
      if (accept && (state == LEN_HI)) len[15:8] <= byte_data;
      // Address and data are latched on entry to WRITE and then held.
      if (word_full) begin
        mem_wdata <= asm_word;
        mem_addr  <= D_WIDTH'(BASE_ADDR) + (D_WIDTH'(idx) << 2);
      end
      if (state == WRITE) idx <= idx + (A_WIDTH+1)'(1);
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: write scoreboard plus explicit output checks per scenario.
module tb_instr_loader;
  import instr_loader_pkg::*;

  logic        clk, rst, start, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, mem_we, cpu_rst, done, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  logic prev_we = 1'b0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_q[$];

  instr_loader dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_rst(cpu_rst),
    .done(done), .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every write strobe is matched against the expected queue
  always @(negedge clk) begin
    if (mem_we) begin
      wr_cnt++;
      check("we_one_cycle", prev_we, 1'b0);
      if (exp_q.size() == 0) begin
        check("unexpected_write", 1'b1, 1'b0);
      end else begin
        check("wr_addr", mem_addr, exp_addr_q.pop_front());
        check("wr_data", mem_wdata, exp_q.pop_front());
      end
    end
    prev_we = mem_we;
  end

  // drivers (called at a falling edge, return at a falling edge)
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 1'b0, 1'b1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic expect_write(input logic [31:0] a, input logic [31:0] w);
    exp_addr_q.push_back(a);
    exp_q.push_back(w);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, done, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, byte_ready, 1'b0);
    check({tag, "_we"},    mem_we,     1'b0);
    check({tag, "_addr"},  mem_addr,   32'h0);
    check({tag, "_wdata"}, mem_wdata,  32'h0);
    check({tag, "_cpurst"}, cpu_rst,   1'b1);
    check({tag, "_done"},  done,       1'b0);
    check({tag, "_err"},   err,        1'b0);
    check({tag, "_state"}, dbg_state,  IDLE);
  endtask

  initial begin
    logic [7:0]  seq[$];
    logic [31:0] w;
    int          base_cnt;

    rst = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b1;
    @(negedge clk);
    check("idle_hold_state", dbg_state, IDLE);

    // two-word load
    expect_write(32'hBFC00000, 32'h00A00513);
    expect_write(32'hBFC00004, 32'h00100593);
    pulse_start();
    check("lenlo_ready", byte_ready, 1'b1);
    seq = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    foreach (seq[i]) send_byte(seq[i]);
    wait_done("two_word_done");
    check("two_word_cpurst", cpu_rst, 1'b0);
    check("two_word_ready", byte_ready, 1'b0);
    check("two_word_count", wr_cnt, 2);
    check("two_word_q_empty", exp_q.size(), 0);

    // zero-length load
    base_cnt = wr_cnt;
    pulse_start();
    check("restart_done_clr", done, 1'b0);
    check("restart_cpurst", cpu_rst, 1'b1);
    send_byte(8'h00);
    send_byte(8'h00);
    check("zero_done", done, 1'b1);
    check("zero_cpurst", cpu_rst, 1'b0);
    check("zero_no_write", wr_cnt, base_cnt);

    // length 257 overflows 256-word memory
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h01);
    check("ovf_err", err, 1'b1);
    check("ovf_state", dbg_state, ERR);
    check("ovf_cpurst", cpu_rst, 1'b1);
    check("ovf_ready", byte_ready, 1'b0);
    check("ovf_done", done, 1'b0);
    check("ovf_no_write", wr_cnt, base_cnt);
    repeat (2) @(negedge clk);
    check("err_holds", err, 1'b1);
    pulse_start();
    check("err_cleared", err, 1'b0);
    check("err_restart_state", dbg_state, LEN_LO);

    // exactly 256 words: largest legal length, last address 0xBFC003FC
    send_byte(8'h00);
    send_byte(8'h01);
    check("full_state", dbg_state, DATA);
    for (int k = 0; k < 256; k++) begin
      w = {k[7:0], ~k[7:0], 8'h5A, k[7:0]};
      expect_write(32'hBFC00000 + 32'(4 * k), w);
      send_word(w);
    end
    wait_done("full_done");
    check("full_count", wr_cnt, base_cnt + 256);
    check("full_last_addr", mem_addr, 32'hBFC003FC);
    check("full_q_empty", exp_q.size(), 0);

    // N=1 with valid toggling and start pulses in every busy state
    base_cnt = wr_cnt;
    expect_write(32'hBFC00000, 32'hDEADBEEF);
    pulse_start();
    seq = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    foreach (seq[i]) begin
      byte_valid = 1'b1;
      byte_data  = seq[i];
      check("toggle_ready", byte_ready, 1'b1);
      @(negedge clk);
      byte_valid = 1'b0;
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
    end
    wait_done("toggle_done");
    check("toggle_count", wr_cnt, base_cnt + 1);
    check("toggle_q_empty", exp_q.size(), 0);

    // reset in the middle of a word, then a clean reload
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    check("mid_state", dbg_state, DATA);
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b1;
    base_cnt = wr_cnt;
    send_byte_idle_check: begin
      byte_valid = 1'b1;
      byte_data  = 8'h77;
      repeat (3) @(negedge clk);
      byte_valid = 1'b0;
    end
    check("post_rst_no_write", wr_cnt, base_cnt);
    check("post_rst_idle", dbg_state, IDLE);
    expect_write(32'hBFC00000, 32'h11223344);
    pulse_start();
    seq = '{8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
    foreach (seq[i]) send_byte(seq[i]);
    wait_done("reload_done");
    check("reload_count", wr_cnt, base_cnt + 1);
    check("reload_q_empty", exp_q.size(), 0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
